// File: rtl/mustang_pkg.sv
// Shared definitions for the Mustang tail-light decoder: lamp pattern codes,
// MODE encoding, tracker states and the transition legality rules.
package mustang_pkg;

  // Pattern codes as {LEDR, LEDL}
  localparam logic [5:0] PAT_OFF = 6'b000_000;
  localparam logic [5:0] PAT_HAZ = 6'b111_111;
  localparam logic [5:0] PAT_R1  = 6'b001_000;
  localparam logic [5:0] PAT_R2  = 6'b011_000;
  localparam logic [5:0] PAT_R3  = 6'b111_000;
  localparam logic [5:0] PAT_L1  = 6'b000_001;
  localparam logic [5:0] PAT_L2  = 6'b000_011;
  localparam logic [5:0] PAT_L3  = 6'b000_111;

  // Decoded lamp mode
  typedef enum logic [1:0] {
    MODE_IDLE  = 2'b00,
    MODE_RIGHT = 2'b01,
    MODE_LEFT  = 2'b10,
    MODE_HAZ   = 2'b11
  } mode_e;

  // Sequence tracker states; SYNC means "no trusted history yet"
  typedef enum logic [3:0] {
    ST_SYNC = 4'd0,
    ST_OFF  = 4'd1,
    ST_HAZ  = 4'd2,
    ST_R1   = 4'd3,
    ST_R2   = 4'd4,
    ST_R3   = 4'd5,
    ST_L1   = 4'd6,
    ST_L2   = 4'd7,
    ST_L3   = 4'd8
  } track_state_e;

  // Mode shown for a tracker state
  function automatic mode_e state_mode(input track_state_e s);
    mode_e m;
    case (s)
      ST_R1, ST_R2, ST_R3: m = MODE_RIGHT;
      ST_L1, ST_L2, ST_L3: m = MODE_LEFT;
      ST_HAZ:              m = MODE_HAZ;
      default:             m = MODE_IDLE;
    endcase
    return m;
  endfunction

  // True when cur -> nxt is an allowed step (nxt is never SYNC here).
  // Repeats are legal because the sequencer may hold a step when hazard
  // pre-empts it.
  function automatic logic is_legal(input track_state_e cur,
                                    input track_state_e nxt);
    logic ok;
    if (cur == nxt || cur == ST_SYNC) begin
      ok = 1'b1;
    end else begin
      case (cur)
        ST_OFF:  ok = (nxt == ST_HAZ) || (nxt == ST_R1) || (nxt == ST_L1);
        ST_R1:   ok = (nxt == ST_R2)  || (nxt == ST_HAZ);
        ST_R2:   ok = (nxt == ST_R3)  || (nxt == ST_HAZ);
        ST_R3:   ok = (nxt == ST_OFF) || (nxt == ST_HAZ);
        ST_L1:   ok = (nxt == ST_L2)  || (nxt == ST_HAZ);
        ST_L2:   ok = (nxt == ST_L3)  || (nxt == ST_HAZ);
        ST_L3:   ok = (nxt == ST_OFF) || (nxt == ST_HAZ);
        ST_HAZ:  ok = (nxt == ST_OFF);
        default: ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

  // A flash cycle ends when the lamps go dark after a full sweep or hazard
  function automatic logic completes_cycle(input track_state_e cur,
                                           input track_state_e nxt);
    return (nxt == ST_OFF) &&
           ((cur == ST_R3) || (cur == ST_L3) || (cur == ST_HAZ));
  endfunction

endpackage

// File: rtl/mustang_pattern_classify.sv
// Combinational map from the raw lamp buses to a tracker state, or BAD.
module mustang_pattern_classify
  import mustang_pkg::*;
(
  input  logic [2:0]   ledr,
  input  logic [2:0]   ledl,
  output track_state_e pat_state,
  output logic         pat_bad
);

  // Match the concatenated buses against the eight legal codes
  always_comb begin
    pat_state = ST_SYNC;
    pat_bad   = 1'b0;
    case ({ledr, ledl})
      PAT_OFF: pat_state = ST_OFF;
      PAT_HAZ: pat_state = ST_HAZ;
      PAT_R1:  pat_state = ST_R1;
      PAT_R2:  pat_state = ST_R2;
      PAT_R3:  pat_state = ST_R3;
      PAT_L1:  pat_state = ST_L1;
      PAT_L2:  pat_state = ST_L2;
      PAT_L3:  pat_state = ST_L3;
      default: pat_bad   = 1'b1;
    endcase
  end

endmodule

// File: rtl/mustang_light_decoder.sv
// Passive decoder/checker for the Mustang tail-light sequencer outputs.
// Samples the lamp buses on STEP, tracks the legal sequence, and reports
// mode, cycle completions and protocol errors with 1-CLK latency.
module mustang_light_decoder
  import mustang_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             STEP,
  input  logic [2:0]       LEDR,
  input  logic [2:0]       LEDL,
  output logic [1:0]       MODE,
  output logic             MODE_VALID,
  output logic             CYCLE_DONE,
  output logic             SEQ_ERR,
  output logic [CNT_W-1:0] CYCLE_CNT,
  output logic [CNT_W-1:0] ERR_CNT
);

  track_state_e     pat_state;
  logic             pat_bad;

  track_state_e     state_q, state_d;
  mode_e            mode_q, mode_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  mustang_pattern_classify u_classify (
    .ledr      (LEDR),
    .ledl      (LEDL),
    .pat_state (pat_state),
    .pat_bad   (pat_bad)
  );

  // Next-state, output and counter update for one STEP sample
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    valid_d   = valid_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    cyc_cnt_d = cyc_cnt_q;
    err_cnt_d = err_cnt_q;
    if (STEP) begin
      if (pat_bad) begin
        // Unknown pattern: lose sync entirely
        state_d = ST_SYNC;
        mode_d  = MODE_IDLE;
        valid_d = 1'b0;
        err_d   = 1'b1;
        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
      end else if (is_legal(state_q, pat_state)) begin
        state_d = pat_state;
        mode_d  = state_mode(pat_state);
        valid_d = 1'b1;
        if (completes_cycle(state_q, pat_state)) begin
          done_d = 1'b1;
          if (cyc_cnt_q != '1) cyc_cnt_d = cyc_cnt_q + CNT_W'(1);
        end
      end else begin
        // Known pattern out of order: resync on it but flag this step
        state_d = pat_state;
        mode_d  = state_mode(pat_state);
        valid_d = 1'b0;
        err_d   = 1'b1;
        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
      end
    end
  end

  // State and output registers; reset overrides any coincident STEP
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= ST_SYNC;
      mode_q    <= MODE_IDLE;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      cyc_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      err_q     <= err_d;
      cyc_cnt_q <= cyc_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign MODE       = mode_q;
  assign MODE_VALID = valid_q;
  assign CYCLE_DONE = done_q;
  assign SEQ_ERR    = err_q;
  assign CYCLE_CNT  = cyc_cnt_q;
  assign ERR_CNT    = err_cnt_q;

endmodule
